// File: rtl/sdam_param.sv
// sdam_param: single-wire serial frame receiver with configurable address/data widths.
// Frame: start(0), mode, ADDR_W address bits LSB first, DATA_W data bits LSB first,
// optional even-parity bit. Completed write frames (mode=1) are presented on a
// valid/ready output port; frames that arrive while a word is held set the sticky ovf.
// Optional feature macro: SDAM_PARITY_EN adds the parity bit, the PAR state and perr.
module sdam_param #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
) (
   input  logic              scl,
   input  logic              reset,
   input  logic              sda,
   input  logic              ready,
   output logic              avalid,
   output logic [ADDR_W-1:0] aout,
   output logic              dvalid,
   output logic [DATA_W-1:0] dout,
   output logic              ovf,
   output logic              perr
);

   localparam logic [5:0] AddrLast = 6'(ADDR_W - 1);
   localparam logic [5:0] DataLast = 6'(DATA_W - 1);

   typedef enum logic [2:0] {
      StIdle,
      StMode,
      StAddr,
      StData
`ifdef SDAM_PARITY_EN
      ,
      StPar
`endif
   } state_e;

   state_e              state_q;
   logic [5:0]          cnt_q;
   logic                mode_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic                avalid_q;
   logic [ADDR_W-1:0]   aout_q;
   logic [DATA_W-1:0]   dout_q;
   logic                ovf_q;

   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   data_d;
   logic [DATA_W-1:0]   word_data;
   logic                frame_done;
   logic                accept;
   logic                load;

`ifdef SDAM_PARITY_EN
   logic                parity_ok;
   logic                perr_q;
`endif

   // Shift-in values and frame-completion decode for the current edge.
   always_comb begin
      addr_d = addr_q >> 1;
      addr_d[ADDR_W-1] = sda;
      data_d = data_q >> 1;
      data_d[DATA_W-1] = sda;
`ifdef SDAM_PARITY_EN
      // Even parity over address, data and the parity bit being sampled now.
      parity_ok  = ~(^{addr_q, data_q, sda});
      frame_done = (state_q == StPar);
      word_data  = data_q;
      accept     = frame_done && mode_q && parity_ok;
`else
      frame_done = (state_q == StData) && (cnt_q == DataLast);
      // Final data bit is still in flight, so load the shifted value directly.
      word_data  = data_d;
      accept     = frame_done && mode_q;
`endif
      // A held word may be replaced only on the edge it is being consumed.
      load = accept && (!avalid_q || ready);
   end

   // Frame FSM, shift registers and registered output port.
   always_ff @(posedge scl) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         mode_q   <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         avalid_q <= 1'b0;
         aout_q   <= '0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
`ifdef SDAM_PARITY_EN
         perr_q   <= 1'b0;
`endif
      end else begin
`ifdef SDAM_PARITY_EN
         perr_q <= frame_done && mode_q && !parity_ok;
`endif
         if (load) begin
            avalid_q <= 1'b1;
            aout_q   <= addr_q;
            dout_q   <= word_data;
         end else if (avalid_q && ready) begin
            avalid_q <= 1'b0;
         end
         if (accept && !load) begin
            ovf_q <= 1'b1;
         end

         unique case (state_q)
            StIdle: begin
               if (!sda) begin
                  state_q <= StMode;
               end
            end
            StMode: begin
               mode_q  <= sda;
               cnt_q   <= '0;
               state_q <= StAddr;
            end
            StAddr: begin
               addr_q <= addr_d;
               if (cnt_q == AddrLast) begin
                  cnt_q   <= '0;
                  state_q <= StData;
               end else begin
                  cnt_q <= cnt_q + 6'd1;
               end
            end
            StData: begin
               data_q <= data_d;
               if (cnt_q == DataLast) begin
                  cnt_q <= '0;
`ifdef SDAM_PARITY_EN
                  state_q <= StPar;
`else
                  state_q <= StIdle;
`endif
               end else begin
                  cnt_q <= cnt_q + 6'd1;
               end
            end
`ifdef SDAM_PARITY_EN
            StPar: begin
               state_q <= StIdle;
            end
`endif
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign avalid = avalid_q;
   assign dvalid = avalid_q;
   assign aout   = aout_q;
   assign dout   = dout_q;
   assign ovf    = ovf_q;
`ifdef SDAM_PARITY_EN
   assign perr   = perr_q;
`else
   assign perr   = 1'b0;
`endif

endmodule
